// File: rtl/bus_arbiter85.sv
// ---------------------------------------------------------------------------
// bus_arbiter85
//   Shares the 8085 system bus between the CPU core and NREQ external bus
//   masters (DMA engines). The arbiter raises hold to the core. Once the core
//   answers with hlda, it grants the bus to one requester at a time in
//   round-robin order.
//
//   Optional feature macro: BUSARB_TIMEOUT_EN
//     defined   : a grant tenure is force-terminated after TOUT cycles. The
//                 victim is masked until its request is seen low once.
//     undefined : tenure is unbounded, tout is tied low.
//
// Ports
//   clk   in   1     system clock, all state on rising edge
//   rst_  in   1     asynchronous active-low reset
//   req   in   NREQ  level bus requests, one per master
//   hlda  in   1     hold acknowledge from the core
//   hold  out  1     hold request to the core
//   gnt   out  NREQ  one-hot bus grant (zero when none)
//   gidx  out  IDXW  index of current/last granted master
//   busy  out  1     high whenever the arbiter is not idle
//   tout  out  1     one-cycle pulse when a tenure is force-terminated
// ---------------------------------------------------------------------------
module bus_arbiter85 #(
   parameter int NREQ  = 4,
   parameter int IDXW  = 2,
   parameter int TOUT  = 200,
   parameter int TOUTW = 8
) (
   input  logic            clk,
   input  logic            rst_,
   input  logic [NREQ-1:0] req,
   input  logic            hlda,
   output logic            hold,
   output logic [NREQ-1:0] gnt,
   output logic [IDXW-1:0] gidx,
   output logic            busy,
   output logic            tout
);

   // Elaboration-time sanity checks on the parameter set.
   if (IDXW != $clog2(NREQ)) begin : g_bad_idxw
      $error("IDXW must equal clog2(NREQ)");
   end
   if (TOUT >= (1 << TOUTW)) begin : g_bad_tout
      $error("TOUT must be below 2**TOUTW");
   end

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HREQ  = 3'd1,
      ST_GRANT = 3'd2,
      ST_RELS  = 3'd3,
      ST_DROP  = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic            hold_q, hold_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [IDXW-1:0] gidx_q, gidx_d;
   logic            busy_q, busy_d;
   logic            tout_q, tout_d;
   logic [NREQ-1:0] avail_s;
   logic [IDXW-1:0] win_s;

`ifdef BUSARB_TIMEOUT_EN
   logic [NREQ-1:0]  mask_q, mask_d;
   logic [TOUTW-1:0] cnt_q, cnt_d;

   // Masked requesters are invisible to every transition.
   assign avail_s = req & ~mask_q;
`else
   assign avail_s = req;
`endif

   // Round-robin pick: first available request after the last granted index.
   always_comb begin
      win_s = gidx_q;
      for (int i = NREQ; i >= 1; i--) begin
         // Scanning backwards lets the nearest candidate overwrite farther ones.
         if (avail_s[(int'(gidx_q) + i) % NREQ]) begin
            win_s = IDXW'((int'(gidx_q) + i) % NREQ);
         end else begin
            win_s = win_s;
         end
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      gidx_d  = gidx_q;
      tout_d  = 1'b0;
`ifdef BUSARB_TIMEOUT_EN
      mask_d  = mask_q & req;   // a mask bit clears once its request is seen low
      cnt_d   = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (|avail_s) begin
               state_d = ST_HREQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HREQ: begin
            if (!(|avail_s)) begin
               state_d = ST_DROP;
            end else if (hlda) begin
               state_d = ST_GRANT;
               gidx_d  = win_s;
`ifdef BUSARB_TIMEOUT_EN
               cnt_d   = {TOUTW{1'b0}};
`endif
            end else begin
               state_d = ST_HREQ;
            end
         end
         ST_GRANT: begin
            // Lost hlda takes precedence so gnt never outlives the acknowledge.
            if (!hlda) begin
               state_d = ST_HREQ;
            end else if (!req[gidx_q]) begin
               state_d = ST_RELS;
`ifdef BUSARB_TIMEOUT_EN
            end else if (cnt_q == TOUTW'(TOUT - 1)) begin
               state_d        = ST_RELS;
               tout_d         = 1'b1;
               mask_d[gidx_q] = 1'b1;
            end else begin
               cnt_d = cnt_q + {{(TOUTW-1){1'b0}}, 1'b1};
`else
            end else begin
               state_d = ST_GRANT;
`endif
            end
         end
         ST_RELS: begin
            // Hand over without dropping hold; only with hlda still present.
            if ((|avail_s) && hlda) begin
               state_d = ST_GRANT;
               gidx_d  = win_s;
`ifdef BUSARB_TIMEOUT_EN
               cnt_d   = {TOUTW{1'b0}};
`endif
            end else if (|avail_s) begin
               state_d = ST_HREQ;
            end else begin
               state_d = ST_DROP;
            end
         end
         ST_DROP: begin
            if (!hlda) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DROP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs follow the next state so they are registered with it.
      hold_d = (state_d == ST_HREQ) || (state_d == ST_GRANT) || (state_d == ST_RELS);
      busy_d = (state_d != ST_IDLE);
      gnt_d  = {NREQ{1'b0}};
      if (state_d == ST_GRANT) begin
         gnt_d[gidx_d] = 1'b1;
      end else begin
         gnt_d = {NREQ{1'b0}};
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q <= ST_IDLE;
         hold_q  <= 1'b0;
         gnt_q   <= {NREQ{1'b0}};
         gidx_q  <= IDXW'(NREQ - 1);
         busy_q  <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         gnt_q   <= gnt_d;
         gidx_q  <= gidx_d;
         busy_q  <= busy_d;
         tout_q  <= tout_d;
      end
   end

`ifdef BUSARB_TIMEOUT_EN
   // Tenure counter and timeout mask.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         mask_q <= {NREQ{1'b0}};
         cnt_q  <= {TOUTW{1'b0}};
      end else begin
         mask_q <= mask_d;
         cnt_q  <= cnt_d;
      end
   end
`endif

   assign hold = hold_q;
   assign gnt  = gnt_q;
   assign gidx = gidx_q;
   assign busy = busy_q;
   assign tout = tout_q;

endmodule

// File: tb/tb_bus_arbiter85.sv
module tb_bus_arbiter85;
   localparam int NREQ = 4;
   localparam int TOUT = 200;
`ifdef BUSARB_TIMEOUT_EN
   localparam bit TOEN = 1'b1;
`else
   localparam bit TOEN = 1'b0;
`endif
   localparam int S_IDLE = 0, S_HREQ = 1, S_GRANT = 2, S_RELS = 3, S_DROP = 4;

   logic       clk = 1'b0;
   logic       rst_;
   logic [3:0] req;
   logic       hlda;
   logic       hold;
   logic [3:0] gnt;
   logic [1:0] gidx;
   logic       busy;
   logic       tout;

   always #5 clk = ~clk;

   bus_arbiter85 #(.NREQ(4), .IDXW(2), .TOUT(TOUT), .TOUTW(8)) dut (
      .clk(clk), .rst_(rst_), .req(req), .hlda(hlda),
      .hold(hold), .gnt(gnt), .gidx(gidx), .busy(busy), .tout(tout)
   );

   typedef struct packed {
      logic       hold;
      logic [3:0] gnt;
      logic [1:0] gidx;
      logic       busy;
      logic       tout;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // reference model state
   int         m_st;
   logic [1:0] m_gidx;
   logic [3:0] m_mask;
   int         m_cnt;
   logic       m_tout;
   logic [1:0] hpipe;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_st = S_IDLE; m_gidx = 2'd3; m_mask = 4'd0; m_cnt = 0; m_tout = 1'b0;
      hpipe = 2'b00;
      sb_q.delete();
   endtask

   // Advances the model over one rising edge with inputs r/h.
   task automatic model_edge(input logic [3:0] r, input logic h);
      logic [3:0] av;
      logic [3:0] nmask;
      int         w;
      int         nxt;
      av    = r & ~m_mask;
      nmask = m_mask & r;
      w     = -1;
      nxt   = m_st;
      m_tout = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (w < 0 && av[(m_gidx + k) % NREQ]) w = (m_gidx + k) % NREQ;
      end
      case (m_st)
         S_IDLE:  if (av != 4'd0) nxt = S_HREQ;
         S_HREQ:  if (av == 4'd0) nxt = S_DROP;
                  else if (h) begin nxt = S_GRANT; m_gidx = 2'(w); m_cnt = 0; end
         S_GRANT: if (!h) nxt = S_HREQ;
                  else if (!r[m_gidx]) nxt = S_RELS;
                  else if (TOEN && m_cnt == TOUT - 1) begin
                     nxt = S_RELS; m_tout = 1'b1; nmask[m_gidx] = 1'b1;
                  end else m_cnt++;
         S_RELS:  if (av != 4'd0 && h) begin nxt = S_GRANT; m_gidx = 2'(w); m_cnt = 0; end
                  else if (av != 4'd0) nxt = S_HREQ;
                  else nxt = S_DROP;
         S_DROP:  if (!h) nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
      if (!TOEN) nmask = 4'd0;
      m_mask = nmask;
      m_st   = nxt;
   endtask

   // One clock: hmode 0/1 forces hlda, 2 lets hlda follow hold two clocks late.
   task automatic cyc(input logic [3:0] r, input int hmode);
      exp_t e;
      req  = r;
      hlda = (hmode == 2) ? hpipe[1] : hmode[0];
      model_edge(req, hlda);
      e.hold = (m_st == S_HREQ) || (m_st == S_GRANT) || (m_st == S_RELS);
      e.gnt  = (m_st == S_GRANT) ? (4'd1 << m_gidx) : 4'd0;
      e.gidx = m_gidx;
      e.busy = (m_st != S_IDLE);
      e.tout = m_tout;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      hpipe = {hpipe[0], hold};
      e = sb_q.pop_front();
      check_val("hold", 32'(hold), 32'(e.hold));
      check_val("gnt",  32'(gnt),  32'(e.gnt));
      check_val("gidx", 32'(gidx), 32'(e.gidx));
      check_val("busy", 32'(busy), 32'(e.busy));
      check_val("tout", 32'(tout), 32'(e.tout));
   endtask

   // Clock with hlda auto until gnt equals want, bounded.
   task automatic wait_gnt(input logic [3:0] r, input logic [3:0] want, input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
         cyc(r, 2);
         if (gnt == want) seen = 1'b1;
      end
      check_val(tag, 32'(gnt), 32'(want));
   endtask

   logic [3:0] order [5];
   logic [3:0] rq;
   bit         any_gnt;
   int         hi_cnt;

   initial begin
      order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
      order[3] = 4'b1000; order[4] = 4'b0001;
      req = 4'd0; hlda = 1'b0; rst_ = 1'b0;
      model_reset();
      #12;
      check_val("rst_hold", 32'(hold), 32'd0);
      check_val("rst_gnt",  32'(gnt),  32'd0);
      check_val("rst_gidx", 32'(gidx), 32'd3);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_tout", 32'(tout), 32'd0);
      @(negedge clk);
      rst_ = 1'b1;

      // 1: single request, hlda two clocks behind hold
      cyc(4'b0001, 2);
      check_val("t1_hold_n1", 32'(hold), 32'd1);
      cyc(4'b0001, 2);
      check_val("t1_no_gnt_yet", 32'(gnt), 32'd0);
      cyc(4'b0001, 2);
      check_val("t1_gnt", 32'(gnt), 32'b0001);
      check_val("t1_gidx", 32'(gidx), 32'd0);

      // 2: all requesting, each drops once in turn
      rq = 4'b1111;
      cyc(rq, 2); cyc(rq, 2);
      for (int g = 0; g < 5; g++) begin
         check_val("t2_order", 32'(gnt), 32'(order[g]));
         if (g < 4) begin
            cyc(rq & ~gnt, 2);                 // release -> RELS
            check_val("t2_rels_gnt0", 32'(gnt), 32'd0);
            check_val("t2_rels_hold", 32'(hold), 32'd1);
            cyc(rq, 2);                        // handover
         end
      end

      // 3: master 2 alone, then withdraws
      cyc(4'b0100, 2);                         // master 0 releases
      cyc(4'b0100, 2);
      check_val("t3_gnt2", 32'(gnt), 32'b0100);
      cyc(4'b0000, 2);
      cyc(4'b0000, 2);
      check_val("t3_drop_hold", 32'(hold), 32'd0);
      for (int i = 0; i < 4; i++) cyc(4'b0000, 2);
      check_val("t3_idle_busy", 32'(busy), 32'd0);

      // 4: hlda lost during grant, then restored
      wait_gnt(4'b0001, 4'b0001, "t4_gnt");
      cyc(4'b0001, 0);
      check_val("t4_gnt_off", 32'(gnt), 32'd0);
      check_val("t4_hold", 32'(hold), 32'd1);
      cyc(4'b0001, 1);
      check_val("t4_regrant", 32'(gnt), 32'b0001);
      for (int i = 0; i < 6; i++) cyc(4'b0000, 2);

      // 5a: request withdrawn before hlda
      any_gnt = 1'b0;
      cyc(4'b0001, 0);
      cyc(4'b0001, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(4'b0000, 0);
         if (gnt != 4'd0) any_gnt = 1'b1;
      end
      check_val("t5_no_gnt", 32'(any_gnt), 32'd0);
      check_val("t5_idle", 32'(busy), 32'd0);

      // 5b: asynchronous reset in the middle of a grant
      hpipe = 2'b00;
      wait_gnt(4'b0010, 4'b0010, "t5_gnt1");
      #2 rst_ = 1'b0;
      #1;
      check_val("t5_rst_hold", 32'(hold), 32'd0);
      check_val("t5_rst_gnt",  32'(gnt),  32'd0);
      check_val("t5_rst_gidx", 32'(gidx), 32'd3);
      check_val("t5_rst_busy", 32'(busy), 32'd0);
      model_reset();
      req = 4'd0; hlda = 1'b0;
      @(negedge clk);
      rst_ = 1'b1;

`ifdef BUSARB_TIMEOUT_EN
      // 6: endless tenure is cut at TOUT cycles
      wait_gnt(4'b0001, 4'b0001, "t6_gnt0");
      hi_cnt = 1;
      for (int i = 0; i < 250 && gnt != 4'd0; i++) begin
         cyc((i > 50) ? 4'b0011 : 4'b0001, 2);
         if (gnt != 4'd0) hi_cnt++;
      end
      check_val("t6_tenure", 32'(hi_cnt), 32'(TOUT));
      check_val("t6_tout", 32'(tout), 32'd1);
      cyc(4'b0011, 2);
      check_val("t6_next", 32'(gnt), 32'b0010);
      check_val("t6_tout_pulse", 32'(tout), 32'd0);
      for (int i = 0; i < 6; i++) cyc(4'b0001, 2);
      check_val("t6_masked_idle", 32'(busy), 32'd0);
      cyc(4'b0000, 2);
      wait_gnt(4'b0001, 4'b0001, "t6_unmasked");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
